id_ex_reg: RTL
==============

ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter NOP_IR  default 4'h0  ir_type value loaded on reset/flush (bubble).
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  reset, asynchronous, active-high.
REQ-004 Port stall  input  1  hold all registered outputs this cycle.
REQ-005 Port flush  input  1  replace the captured instruction with a bubble.
REQ-006 Port id_valid  input  1  ID stage presents a real instruction.
REQ-007 Port id_ir_type  input  4  instruction class from decoder.
REQ-008 Port id_funct3  input  3  funct3 field.
REQ-009 Port id_in1, id_in2  input  32 each  ALU operands from operand-select logic.
REQ-010 Port id_data2  input  32  rs2 value (store data / branch compare).
REQ-011 Port id_pc, id_imm  input  32 each  instruction PC and immediate.
REQ-012 Port id_rd  input  5  destination register index.
REQ-013 Port id_wr_reg_n  input  1  register write enable, active-low.
REQ-014 Ports ex_valid, ex_ir_type, ex_funct3, ex_in1, ex_in2, ex_data2, ex_pc, ex_imm, ex_rd, ex_wr_reg_n  output, widths as inputs  registered copies for EX.
REQ-015 Port bubble_cnt  output  8  saturating count of bubbles inserted by flush since reset.

Function
REQ-016 Capture: on rising edge with stall=0, flush=0, every ex_* SHALL take its id_* value; latency exactly 1 cycle.
REQ-017 Stall: stall=1, flush=0 SHALL hold every ex_* output unchanged, regardless of id_* inputs.
REQ-018 Flush: flush=1 SHALL load a bubble on the next edge: ex_valid=0, ex_ir_type=NOP_IR, ex_funct3=0, ex_in1/in2/data2/imm=0, ex_rd=0, ex_wr_reg_n=1; ex_pc SHALL still take id_pc.
REQ-019 Priority: flush SHALL override stall when both are 1 (bubble loaded, not held).
REQ-020 id_valid=0 with stall=0, flush=0 SHALL be captured as a bubble identical to REQ-018 except ex_pc=id_pc; bubble_cnt SHALL NOT increment.
REQ-021 Write-enable safety: ex_wr_reg_n SHALL be 1 whenever ex_valid=0; ex_rd SHALL be 0 whenever ex_valid=0.
REQ-022 bubble_cnt SHALL increment by 1 on each edge where flush=1 and the previously-held or incoming instruction was valid (ex_valid=1 with stall=1, or id_valid=1 with stall=0).
REQ-023 bubble_cnt SHALL saturate at 8'hFF, never wrap.
REQ-024 Consecutive flushes SHALL each produce a bubble; the output remains a bubble with no intermediate valid cycle.
REQ-025 No combinational path from any input to any output; all outputs driven directly from flops.

Reset
REQ-026 rst=1 SHALL immediately (asynchronously, without clock) force: ex_valid=0, ex_ir_type=NOP_IR, ex_funct3=0, ex_in1/in2/data2/pc/imm=32'h0, ex_rd=0, ex_wr_reg_n=1, bubble_cnt=0.
REQ-027 While rst=1, stall/flush/id_* SHALL be ignored; outputs hold reset values.
REQ-028 Reset asserted mid-stall SHALL discard the held instruction; after deassertion the first edge with stall=0 captures id_* normally.

Verification
REQ-029 Capture: id_valid=1, id_pc=32'h0000_0100, id_in1=32'h5, id_in2=32'h7, id_rd=3, id_wr_reg_n=0, one edge -> ex_valid=1, ex_pc=32'h100, ex_in1=5, ex_in2=7, ex_rd=3, ex_wr_reg_n=0.
REQ-030 Stall: after REQ-029, change id_pc=32'h104, stall=1 for 3 edges -> ex_pc stays 32'h100, ex_valid=1 all 3 cycles; stall=0 next edge -> ex_pc=32'h104.
REQ-031 Flush+stall: ex holds valid instruction, stall=1 and flush=1, id_pc=32'h200 -> next edge ex_valid=0, ex_wr_reg_n=1, ex_rd=0, ex_ir_type=NOP_IR, ex_pc=32'h200, bubble_cnt=1.
REQ-032 Invalid input: id_valid=0, id_rd=7, id_wr_reg_n=0 -> ex_valid=0, ex_rd=0, ex_wr_reg_n=1, bubble_cnt unchanged.
REQ-033 Saturation: 300 consecutive flushes with id_valid=1 -> bubble_cnt=8'hFF, no wrap to 0.
REQ-034 Async reset: assert rst between clock edges while ex_valid=1, ex_in1=32'hDEAD_BEEF -> outputs reach reset values before next rising edge; bubble_cnt=0.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decoded operands for EX, with stall hold,
// flush-to-bubble and a saturating count of flushed-out valid instructions.
module id_ex_reg #(
    parameter logic [3:0] NOP_IR = 4'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [3:0]  id_ir_type,
    input  logic [2:0]  id_funct3,
    input  logic [31:0] id_in1,
    input  logic [31:0] id_in2,
    input  logic [31:0] id_data2,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rd,
    input  logic        id_wr_reg_n,
    output logic        ex_valid,
    output logic [3:0]  ex_ir_type,
    output logic [2:0]  ex_funct3,
    output logic [31:0] ex_in1,
    output logic [31:0] ex_in2,
    output logic [31:0] ex_data2,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic        ex_wr_reg_n,
    output logic [7:0]  bubble_cnt
);

    typedef struct packed {
        logic        valid;
        logic [3:0]  ir_type;
        logic [2:0]  funct3;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [31:0] data2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wr_reg_n;
    } ex_pkt_t;

    localparam ex_pkt_t RST_PKT = '{
        valid: 1'b0, ir_type: NOP_IR, funct3: 3'd0, in1: 32'd0, in2: 32'd0,
        data2: 32'd0, pc: 32'd0, imm: 32'd0, rd: 5'd0, wr_reg_n: 1'b1
    };

    ex_pkt_t    pkt_q, pkt_d;
    ex_pkt_t    id_pkt, bubble_pkt;
    logic [7:0] bubble_cnt_q, bubble_cnt_d;
    logic       cnt_inc;

    always_comb begin
        id_pkt.valid    = 1'b1;
        id_pkt.ir_type  = id_ir_type;
        id_pkt.funct3   = id_funct3;
        id_pkt.in1      = id_in1;
        id_pkt.in2      = id_in2;
        id_pkt.data2    = id_data2;
        id_pkt.pc       = id_pc;
        id_pkt.imm      = id_imm;
        id_pkt.rd       = id_rd;
        id_pkt.wr_reg_n = id_wr_reg_n;

        // A bubble keeps the PC so EX still knows where the slot came from.
        bubble_pkt    = RST_PKT;
        bubble_pkt.pc = id_pc;

        pkt_d = pkt_q;
        if (flush) begin
            pkt_d = bubble_pkt;
        end else if (!stall) begin
            pkt_d = id_valid ? id_pkt : bubble_pkt;
        end

        // Count only flushes that actually killed a real instruction.
        cnt_inc      = flush && (stall ? pkt_q.valid : id_valid);
        bubble_cnt_d = bubble_cnt_q;
        if (cnt_inc && (bubble_cnt_q != 8'hFF)) begin
            bubble_cnt_d = bubble_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_q        <= RST_PKT;
            bubble_cnt_q <= 8'd0;
        end else begin
            pkt_q        <= pkt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_valid    = pkt_q.valid;
    assign ex_ir_type  = pkt_q.ir_type;
    assign ex_funct3   = pkt_q.funct3;
    assign ex_in1      = pkt_q.in1;
    assign ex_in2      = pkt_q.in2;
    assign ex_data2    = pkt_q.data2;
    assign ex_pc       = pkt_q.pc;
    assign ex_imm      = pkt_q.imm;
    assign ex_rd       = pkt_q.rd;
    assign ex_wr_reg_n = pkt_q.wr_reg_n;
    assign bubble_cnt  = bubble_cnt_q;

endmodule
